machine_irq_ctrl: RTL and testbench

//  Machine-mode interrupt source for the core: memory-mapped mtime/mtimecmp timer, software-interrupt register, synchronised external line.

---
 rtl/machine_irq_ctrl.sv | 125 ++++++++++++
 tb/tb_machine_irq_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/machine_irq_ctrl.sv
// machine_irq_ctrl: machine-mode timer/software/external interrupt source with held request to trap entry
module machine_irq_ctrl #(
    parameter int unsigned TICK_DIV     = 16,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter int unsigned GUARD        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_en,
    input  logic        bus_we,
    input  logic [4:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_err,
    input  logic        ext_irq,
    input  logic        mstatus_mie,
    input  logic [31:0] mie,
    output logic [31:0] mip,
    output logic        irq_req,
    output logic [4:0]  irq_cause,
    input  logic        irq_ack
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int GW = GUARD > 0 ? $clog2(GUARD + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, GUARD_WAIT} state_t;

    state_t        state, state_nxt;
    logic [63:0]   mtime, mtimecmp;
    logic          msip;
    logic [PW-1:0] presc;
    logic [1:0]    sync;
    logic [GW-1:0] guard, guard_nxt;
    logic [4:0]    cause_nxt;
    logic [31:0]   rd_val, en;
    logic          tick, mtip, meip, wr, rd;

    assign bus_err = bus_en & ((bus_addr > 5'h10) | (bus_addr[1:0] != 2'b00));
    assign wr      = bus_en & bus_we & ~bus_err;
    assign rd      = bus_en & ~bus_we & ~bus_err;
    assign tick    = presc == PW'(TICK_DIV - 1);
    assign mtip    = mtime >= mtimecmp;
    assign meip    = sync[1];
    assign mip     = {20'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0};
    assign en      = mip & mie & {32{mstatus_mie}};
    assign irq_req = state == REQ;

    // read mux over the five mapped words
    always_comb begin
        rd_val = bus_addr == 5'h00 ? {31'b0, msip} :
                 bus_addr == 5'h04 ? mtimecmp[31:0] :
                 bus_addr == 5'h08 ? mtimecmp[63:32] :
                 bus_addr == 5'h0C ? mtime[31:0] : mtime[63:32];
    end

    // prescaler, mtime (a write to either half beats a tick in the same cycle), synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            mtime <= '0;
            sync  <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            mtime <= (wr && bus_addr == 5'h0C) ? {mtime[63:32], bus_wdata} :
                     (wr && bus_addr == 5'h10) ? {bus_wdata, mtime[31:0]} :
                     tick ? mtime + 64'd1 : mtime;
            sync  <= {sync[0], ext_irq};
        end
    end

    // software-visible registers and registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp  <= MTIMECMP_RST;
            msip      <= 1'b0;
            bus_rdata <= '0;
        end else begin
            mtimecmp  <= (wr && bus_addr == 5'h04) ? {mtimecmp[63:32], bus_wdata} :
                         (wr && bus_addr == 5'h08) ? {bus_wdata, mtimecmp[31:0]} : mtimecmp;
            msip      <= (wr && bus_addr == 5'h00) ? bus_wdata[0] : msip;
            bus_rdata <= rd ? rd_val : '0;
        end
    end

    // request FSM state, frozen cause and guard counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            irq_cause <= '0;
            guard     <= '0;
        end else begin
            state     <= state_nxt;
            irq_cause <= cause_nxt;
            guard     <= guard_nxt;
        end
    end

    // arbitration in IDLE only; ack beats withdrawal; guard leaves as it reaches zero
    always_comb begin
        state_nxt = state;
        cause_nxt = irq_cause;
        guard_nxt = guard;
        unique case (state)
            IDLE: begin
                if (en != 32'b0) begin
                    state_nxt = REQ;
                    cause_nxt = en[11] ? 5'd11 : en[3] ? 5'd3 : 5'd7;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_nxt = GUARD_WAIT;
                    guard_nxt = GW'(GUARD);
                end else if (!en[irq_cause]) begin
                    state_nxt = IDLE;
                end
            end
            GUARD_WAIT: begin
                guard_nxt = guard == '0 ? '0 : guard - GW'(1);
                state_nxt = guard <= GW'(1) ? IDLE : GUARD_WAIT;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_machine_irq_ctrl.sv
// tb_machine_irq_ctrl: directed-vector bench for machine_irq_ctrl with TICK_DIV=1, GUARD=3
module tb_machine_irq_ctrl;
    logic        clk, rst;
    logic        bus_en, bus_we, bus_err, ext_irq, mstatus_mie, irq_req, irq_ack;
    logic [4:0]  bus_addr, irq_cause;
    logic [31:0] bus_wdata, bus_rdata, mie, mip;
    logic [31:0] d;
    logic        e;
    int          n_chk, n_fail;
    int          first_mtip, first_req, n;

    machine_irq_ctrl #(.TICK_DIV(1), .MTIMECMP_RST(64'hFFFF_FFFF_FFFF_FFFF), .GUARD(3)) dut (
        .clk(clk), .rst(rst), .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_err(bus_err), .ext_irq(ext_irq),
        .mstatus_mie(mstatus_mie), .mie(mie), .mip(mip), .irq_req(irq_req),
        .irq_cause(irq_cause), .irq_ack(irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] wd);
        bus_en = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = wd;
        step();
        bus_en = 1'b0; bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] rd, output logic er);
        bus_en = 1'b1; bus_we = 1'b0; bus_addr = a;
        #1 er = bus_err;
        step();
        rd = bus_rdata;
        bus_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b1; bus_en = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        ext_irq = 1'b0; mstatus_mie = 1'b0; mie = '0; irq_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_req", irq_req, 0);
        check("rst_cause", irq_cause, 0);
        check("rst_mip", mip, 0);
        check("rst_rdata", bus_rdata, 0);
        bus_read(5'h08, d, e);
        check("rst_cmp_hi", d, 32'hFFFF_FFFF);
        bus_read(5'h04, d, e);
        check("rst_cmp_lo", d, 32'hFFFF_FFFF);

        // timer interrupt at mtime == 20
        mie = 32'h80; mstatus_mie = 1'b1;
        bus_write(5'h08, 32'd0);
        bus_write(5'h04, 32'd20);
        bus_write(5'h10, 32'd0);
        bus_write(5'h0C, 32'd0);
        first_mtip = -1; first_req = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (mip[7] && first_mtip < 0) first_mtip = k;
            if (irq_req && first_req < 0) first_req = k;
        end
        check("mtip_time", first_mtip, 20);
        check("mti_req_time", first_req, 21);
        check("mti_cause", irq_cause, 7);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        n = 0;
        while (!irq_req && n < 20) begin n++; step(); end
        check("guard_low_cycles", n, 4);
        check("mti_cause_again", irq_cause, 7);
        mie = '0;
        bus_write(5'h08, 32'hFFFF_FFFF);
        step();
        check("mti_withdrawn", irq_req, 0);

        // priority: external beats software
        mie = 32'h888; mstatus_mie = 1'b0; ext_irq = 1'b1;
        bus_write(5'h00, 32'd1);
        step();
        check("prio_mip", mip, 32'h808);
        mstatus_mie = 1'b1;
        step();
        check("prio_req", irq_req, 1);
        check("prio_cause", irq_cause, 11);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        ext_irq = 1'b0;
        bus_write(5'h00, 32'd0);
        n = 0;
        for (int k = 0; k < 10; k++) begin step(); if (irq_req) n++; end
        check("prio_no_more", n, 0);
        check("prio_mip_clear", mip, 0);

        // withdrawal of a software request, then stray ack
        mie = 32'h8;
        bus_write(5'h00, 32'd1);
        step();
        check("msi_req", irq_req, 1);
        check("msi_cause", irq_cause, 3);
        mie = '0;
        step();
        check("msi_withdraw", irq_req, 0);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        mie = 32'h8;
        step();
        check("stray_ack_ignored", irq_req, 1);
        mie = '0;
        step();
        bus_write(5'h00, 32'd0);

        // mtime wrap and write-vs-tick race
        bus_write(5'h10, 32'hFFFF_FFFF);
        bus_write(5'h0C, 32'hFFFF_FFFF);
        check("all_ones_mtip", mip[7], 1);
        bus_read(5'h0C, d, e);
        check("ones_lo", d, 32'hFFFF_FFFF);
        check("wrap_mtip_clear", mip[7], 0);
        bus_read(5'h10, d, e);
        check("wrap_hi", d, 0);
        bus_read(5'h0C, d, e);
        check("wrap_lo_next", d, 1);
        bus_write(5'h0C, 32'd5);
        bus_read(5'h0C, d, e);
        check("race_lo", d, 5);
        bus_read(5'h10, d, e);
        check("race_hi", d, 0);

        // bus errors and msip masking
        bus_write(5'h06, 32'd1);
        bus_write(5'h01, 32'd1);
        bus_write(5'h14, 32'd0);
        bus_read(5'h04, d, e);
        check("err_cmp_lo_kept", d, 20);
        bus_read(5'h00, d, e);
        check("err_msip_kept", d, 0);
        bus_read(5'h08, d, e);
        bus_read(5'h14, d, e);
        check("err14_flag", e, 1);
        check("err14_rdata", d, 0);
        bus_read(5'h04, d, e);
        bus_read(5'h06, d, e);
        check("err06_flag", e, 1);
        check("err06_rdata", d, 0);
        bus_read(5'h10, d, e);
        check("ok10_flag", e, 0);
        bus_write(5'h00, 32'hFFFF_FFFE);
        bus_read(5'h00, d, e);
        check("msip_bit0_only", d, 0);
        bus_write(5'h00, 32'd3);
        bus_read(5'h00, d, e);
        check("msip_read", d, 1);
        bus_write(5'h00, 32'd0);

        // reset during an active request
        mie = 32'h8;
        bus_write(5'h00, 32'd1);
        step();
        check("pre_rst_req", irq_req, 1);
        rst = 1'b1;
        step();
        check("mid_rst_req", irq_req, 0);
        check("mid_rst_mip", mip, 0);
        rst = 1'b0;
        bus_read(5'h0C, d, e);
        check("mid_rst_mtime0", d, 0);
        bus_read(5'h0C, d, e);
        check("mid_rst_mtime1", d, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
